// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV64I decode constants, enums and the ID/EX bundle.
// Imported by the decode stage and its register file.
package riscv_pkg;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  localparam logic [6:0] LOAD      = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] AUIPC     = 7'h17;
  localparam logic [6:0] OP_IMM_32 = 7'h1B;
  localparam logic [6:0] STORE     = 7'h23;
  localparam logic [6:0] OP        = 7'h33;
  localparam logic [6:0] LUI       = 7'h37;
  localparam logic [6:0] OP_32     = 7'h3B;
  localparam logic [6:0] BRANCH    = 7'h63;
  localparam logic [6:0] JALR      = 7'h67;
  localparam logic [6:0] JAL       = 7'h6F;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1d;
    logic [XLEN-1:0] rs2d;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    alu_op_e         alu;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_word;
    logic [2:0]      funct3;
    logic            illegal;
  } id_ex_t;

  function automatic logic [XLEN-1:0] imm_gen(
    input logic [31:0] i,
    input imm_t        t
  );
    logic [XLEN-1:0] r;
    r = '0;
    case (t)
      IMM_I: r = {{(XLEN-12){i[31]}}, i[31:20]};
      IMM_S: r = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
      IMM_B: r = {{(XLEN-13){i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      IMM_U: r = {{(XLEN-32){i[31]}}, i[31:12], 12'h000};
      IMM_J: r = {{(XLEN-21){i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  // alt selects SUB/SRA; callers gate it for immediate forms
  function automatic alu_op_e alu_sel(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 32x64 integer registers, two read ports, one write port.
// Reads see a same-cycle write; x0 always reads zero.
import riscv_pkg::*;

module reg_file (
  input  logic            CLK,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = mem[raddr1];
    if (raddr1 == 5'd0) rdata1 = '0;
    else if (we && waddr == raddr1) rdata1 = wdata;
  end

  always_comb begin
    rdata2 = mem[raddr2];
    if (raddr2 == 5'd0) rdata2 = '0;
    else if (we && waddr == raddr2) rdata2 = wdata;
  end
endmodule

// File: rtl/inst_decode.sv
// inst_decode: RV64I decode stage feeding the ID/EX register.
// Reads operands, builds immediates and stalls fetch on load-use.
import riscv_pkg::*;

module inst_decode (
  input  logic            CLK,
  input  logic            reset,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  input  logic            ex_stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [3:0]      alu_op,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_word,
  output logic [2:0]      funct3_o,
  output logic            illegal
);
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1_f, rs2_f, rd_f;
  logic [XLEN-1:0] rs1d, rs2d;
  logic            ok, wr, use1, use2, hazard;
  imm_t            it;
  id_ex_t          d, q;

  assign opc   = inst_i[6:0];
  assign rd_f  = inst_i[11:7];
  assign f3    = inst_i[14:12];
  assign rs1_f = inst_i[19:15];
  assign rs2_f = inst_i[24:20];
  assign f7    = inst_i[31:25];

  reg_file u_rf (
    .CLK    (CLK),
    .reset  (reset),
    .raddr1 (rs1_f),
    .raddr2 (rs2_f),
    .rdata1 (rs1d),
    .rdata2 (rs2d),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  always_comb begin
    d        = '0;
    d.valid  = valid_i;
    d.pc     = pc_i;
    d.rs1d   = rs1d;
    d.rs2d   = rs2d;
    d.funct3 = f3;
    d.alu    = ALU_ADD;
    ok       = 1'b1;
    wr       = 1'b0;
    use1     = 1'b1;
    use2     = 1'b0;
    it       = IMM_NONE;
    unique case (1'b1)
      (opc == OP): begin
        use2  = 1'b1;
        wr    = 1'b1;
        ok    = (f7 == 7'h00) ||
                (f7 == 7'h20 &&
                 (f3 == 3'b000 || f3 == 3'b101));
        d.alu = alu_sel(f3, inst_i[30]);
      end
      (opc == OP_32): begin
        use2      = 1'b1;
        wr        = 1'b1;
        d.is_word = 1'b1;
        ok = (f7 == 7'h00 &&
              (f3 == 3'b000 || f3 == 3'b001 ||
               f3 == 3'b101)) ||
             (f7 == 7'h20 &&
              (f3 == 3'b000 || f3 == 3'b101));
        d.alu = alu_sel(f3, inst_i[30]);
      end
      (opc == OP_IMM): begin
        wr = 1'b1;
        it = IMM_I;
        ok = (f3 != 3'b001 && f3 != 3'b101) ||
             inst_i[31:26] == 6'h00 ||
             (f3 == 3'b101 && inst_i[31:26] == 6'h10);
        d.alu = alu_sel(f3, f3 == 3'b101 && inst_i[30]);
      end
      (opc == OP_IMM_32): begin
        wr        = 1'b1;
        it        = IMM_I;
        d.is_word = 1'b1;
        ok = f3 == 3'b000 ||
             (f3 == 3'b001 && f7 == 7'h00) ||
             (f3 == 3'b101 &&
              (f7 == 7'h00 || f7 == 7'h20));
        d.alu = alu_sel(f3, f3 == 3'b101 && inst_i[30]);
      end
      (opc == LOAD): begin
        wr        = 1'b1;
        it        = IMM_I;
        d.is_load = 1'b1;
        ok        = f3 != 3'b111;
      end
      (opc == STORE): begin
        use2       = 1'b1;
        it         = IMM_S;
        d.is_store = 1'b1;
        ok         = !f3[2];
      end
      (opc == BRANCH): begin
        use2        = 1'b1;
        it          = IMM_B;
        d.is_branch = 1'b1;
        d.alu       = ALU_SUB;
        ok          = f3[2:1] != 2'b01;
      end
      (opc == JAL): begin
        use1     = 1'b0;
        wr       = 1'b1;
        it       = IMM_J;
        d.is_jal = 1'b1;
      end
      (opc == JALR): begin
        wr        = 1'b1;
        it        = IMM_I;
        d.is_jalr = 1'b1;
        ok        = f3 == 3'b000;
      end
      (opc == LUI): begin
        use1  = 1'b0;
        wr    = 1'b1;
        it    = IMM_U;
        d.alu = ALU_PASSB;
      end
      (opc == AUIPC): begin
        use1 = 1'b0;
        wr   = 1'b1;
        it   = IMM_U;
      end
      default: ok = 1'b0;
    endcase
    // illegal words still flow to EX, but carry no side effects
    if (!ok) begin
      wr          = 1'b0;
      d.alu       = ALU_ADD;
      d.is_load   = 1'b0;
      d.is_store  = 1'b0;
      d.is_branch = 1'b0;
      d.is_jal    = 1'b0;
      d.is_jalr   = 1'b0;
      d.is_word   = 1'b0;
    end
    d.illegal = !ok;
    d.rd      = wr ? rd_f : 5'd0;
    d.imm     = imm_gen(inst_i, it);
  end

  assign hazard = valid_i && q.valid && q.is_load &&
                  q.rd != 5'd0 &&
                  ((q.rd == rs1_f && use1) ||
                   (q.rd == rs2_f && use2));
  assign stall  = ex_stall | hazard;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (!ex_stall) begin
      if (hazard) q.valid <= 1'b0;
      else        q <= d;
    end
  end

  assign id_valid  = q.valid;
  assign id_pc     = q.pc;
  assign rs1_data  = q.rs1d;
  assign rs2_data  = q.rs2d;
  assign imm       = q.imm;
  assign rd        = q.rd;
  assign alu_op    = q.alu;
  assign is_load   = q.is_load;
  assign is_store  = q.is_store;
  assign is_branch = q.is_branch;
  assign is_jal    = q.is_jal;
  assign is_jalr   = q.is_jalr;
  assign is_word   = q.is_word;
  assign funct3_o  = q.funct3;
  assign illegal   = q.illegal;
endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode: directed plus random checks of the decode stage
// against an instruction-kind reference model.
import riscv_pkg::*;

module tb_inst_decode;
  logic        CLK, reset;
  logic [31:0] inst_i;
  logic [63:0] pc_i, wb_data;
  logic        valid_i, ex_stall, flush, wb_en;
  logic [4:0]  wb_rd;
  logic        stall, id_valid;
  logic [63:0] id_pc, rs1_data, rs2_data, imm;
  logic [4:0]  rd;
  logic [3:0]  alu_op;
  logic        is_load, is_store, is_branch;
  logic        is_jal, is_jalr, is_word;
  logic [2:0]  funct3_o;
  logic        illegal;

  inst_decode dut (
    .CLK(CLK), .reset(reset), .inst_i(inst_i), .pc_i(pc_i),
    .valid_i(valid_i), .ex_stall(ex_stall), .flush(flush),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .id_valid(id_valid), .id_pc(id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rd(rd), .alu_op(alu_op), .is_load(is_load),
    .is_store(is_store), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .is_word(is_word),
    .funct3_o(funct3_o), .illegal(illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // fmt: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shift64, 7 shift32
  // fl: {load, store, branch, jal, jalr, word}
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] alu;
    logic [5:0] fl;
    int         fmt;
    logic       ill;
  } kind_t;

  typedef struct {
    logic [63:0] imm;
    logic        ichk;
    logic [3:0]  alu;
    logic        achk;
    logic [4:0]  rd;
    logic [5:0]  fl;
    logic        ill;
  } dexp_t;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] regs [32];
  logic        m_valid;
  logic [63:0] m_pc, m_a, m_b;
  logic [2:0]  m_f3;
  dexp_t       m_d;

  localparam int NK = 36;

  function automatic kind_t mk(
    input logic [6:0] o, input logic [2:0] f3,
    input logic [6:0] f7, input logic [3:0] alu,
    input logic [5:0] fl, input int fmt, input logic ill
  );
    kind_t k;
    k.opc = o; k.f3 = f3; k.f7 = f7; k.alu = alu;
    k.fl = fl; k.fmt = fmt; k.ill = ill;
    return k;
  endfunction

  function automatic kind_t kind_of(input int n);
    case (n)
      0:  return mk(7'h33, 3'd0, 7'h00, ALU_ADD,  6'o00, 0, 1'b0);
      1:  return mk(7'h33, 3'd0, 7'h20, ALU_SUB,  6'o00, 0, 1'b0);
      2:  return mk(7'h33, 3'd1, 7'h00, ALU_SLL,  6'o00, 0, 1'b0);
      3:  return mk(7'h33, 3'd2, 7'h00, ALU_SLT,  6'o00, 0, 1'b0);
      4:  return mk(7'h33, 3'd3, 7'h00, ALU_SLTU, 6'o00, 0, 1'b0);
      5:  return mk(7'h33, 3'd4, 7'h00, ALU_XOR,  6'o00, 0, 1'b0);
      6:  return mk(7'h33, 3'd5, 7'h00, ALU_SRL,  6'o00, 0, 1'b0);
      7:  return mk(7'h33, 3'd5, 7'h20, ALU_SRA,  6'o00, 0, 1'b0);
      8:  return mk(7'h33, 3'd6, 7'h00, ALU_OR,   6'o00, 0, 1'b0);
      9:  return mk(7'h33, 3'd7, 7'h00, ALU_AND,  6'o00, 0, 1'b0);
      10: return mk(7'h3B, 3'd0, 7'h00, ALU_ADD,  6'o01, 0, 1'b0);
      11: return mk(7'h3B, 3'd0, 7'h20, ALU_SUB,  6'o01, 0, 1'b0);
      12: return mk(7'h3B, 3'd5, 7'h20, ALU_SRA,  6'o01, 0, 1'b0);
      13: return mk(7'h13, 3'd0, 7'h00, ALU_ADD,  6'o00, 1, 1'b0);
      14: return mk(7'h13, 3'd2, 7'h00, ALU_SLT,  6'o00, 1, 1'b0);
      15: return mk(7'h13, 3'd4, 7'h00, ALU_XOR,  6'o00, 1, 1'b0);
      16: return mk(7'h13, 3'd7, 7'h00, ALU_AND,  6'o00, 1, 1'b0);
      17: return mk(7'h13, 3'd1, 7'h00, ALU_SLL,  6'o00, 6, 1'b0);
      18: return mk(7'h13, 3'd5, 7'h20, ALU_SRA,  6'o00, 6, 1'b0);
      19: return mk(7'h1B, 3'd0, 7'h00, ALU_ADD,  6'o01, 1, 1'b0);
      20: return mk(7'h1B, 3'd5, 7'h20, ALU_SRA,  6'o01, 7, 1'b0);
      21: return mk(7'h03, 3'd3, 7'h00, ALU_ADD,  6'o40, 1, 1'b0);
      22: return mk(7'h03, 3'd4, 7'h00, ALU_ADD,  6'o40, 1, 1'b0);
      23: return mk(7'h23, 3'd3, 7'h00, ALU_ADD,  6'o20, 2, 1'b0);
      24: return mk(7'h23, 3'd0, 7'h00, ALU_ADD,  6'o20, 2, 1'b0);
      25: return mk(7'h63, 3'd0, 7'h00, ALU_SUB,  6'o10, 3, 1'b0);
      26: return mk(7'h63, 3'd6, 7'h00, ALU_SUB,  6'o10, 3, 1'b0);
      27: return mk(7'h6F, 3'd0, 7'h00, ALU_ADD,  6'o04, 5, 1'b0);
      28: return mk(7'h67, 3'd0, 7'h00, ALU_ADD,  6'o02, 1, 1'b0);
      29: return mk(7'h37, 3'd0, 7'h00, ALU_PASSB, 6'o00, 4, 1'b0);
      30: return mk(7'h17, 3'd0, 7'h00, ALU_ADD,  6'o00, 4, 1'b0);
      31: return mk(7'h7F, 3'd0, 7'h00, ALU_ADD,  6'o00, 0, 1'b1);
      32: return mk(7'h33, 3'd0, 7'h01, ALU_ADD,  6'o00, 0, 1'b1);
      33: return mk(7'h03, 3'd7, 7'h00, ALU_ADD,  6'o00, 1, 1'b1);
      34: return mk(7'h63, 3'd2, 7'h00, ALU_ADD,  6'o00, 3, 1'b1);
      default: return mk(7'h67, 3'd1, 7'h00, ALU_ADD, 6'o00, 1, 1'b1);
    endcase
  endfunction

  // build an instruction word from a chosen immediate value
  function automatic void enc(
    input kind_t k, input logic [4:0] rdn, input logic [4:0] r1,
    input logic [4:0] r2, input logic [31:0] r,
    output logic [31:0] ins, output logic [63:0] im
  );
    logic [20:0] v;
    v = r[20:0];
    case (k.fmt)
      1: begin
        ins = {v[11:0], r1, k.f3, rdn, k.opc};
        im  = {{52{v[11]}}, v[11:0]};
      end
      2: begin
        ins = {v[11:5], r2, r1, k.f3, v[4:0], k.opc};
        im  = {{52{v[11]}}, v[11:0]};
      end
      3: begin
        ins = {v[12], v[10:5], r2, r1, k.f3, v[4:1], v[11], k.opc};
        im  = {{51{v[12]}}, v[12:1], 1'b0};
      end
      4: begin
        ins = {r[31:12], rdn, k.opc};
        im  = {{32{r[31]}}, r[31:12], 12'h000};
      end
      5: begin
        ins = {v[20], v[10:1], v[11], v[19:12], rdn, k.opc};
        im  = {{43{v[20]}}, v[20:1], 1'b0};
      end
      6: begin
        ins = {k.f7[6:1], v[5:0], r1, k.f3, rdn, k.opc};
        im  = {52'd0, k.f7[6:1], v[5:0]};
      end
      7: begin
        ins = {k.f7, v[4:0], r1, k.f3, rdn, k.opc};
        im  = {52'd0, k.f7, v[4:0]};
      end
      default: begin
        ins = {k.f7, r2, r1, k.f3, rdn, k.opc};
        im  = 64'd0;
      end
    endcase
  endfunction

  function automatic dexp_t dx(
    input logic [63:0] im, input logic ichk, input logic [3:0] alu,
    input logic achk, input logic [4:0] rdn, input logic [5:0] fl,
    input logic ill
  );
    dexp_t e;
    e.imm = im; e.ichk = ichk; e.alu = alu; e.achk = achk;
    e.rd = rdn; e.fl = fl; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("id_valid", 64'(id_valid), 64'(m_valid));
    if (m_valid) begin
      chk("id_pc", id_pc, m_pc);
      chk("rs1_data", rs1_data, m_a);
      chk("rs2_data", rs2_data, m_b);
      chk("rd", 64'(rd), 64'(m_d.rd));
      chk("flags", 64'({is_load, is_store, is_branch,
                        is_jal, is_jalr, is_word}), 64'(m_d.fl));
      chk("funct3_o", 64'(funct3_o), 64'(m_f3));
      chk("illegal", 64'(illegal), 64'(m_d.ill));
      if (m_d.ichk) chk("imm", imm, m_d.imm);
      if (m_d.achk) chk("alu_op", 64'(alu_op), 64'(m_d.alu));
    end
  endtask

  // one cycle: drive, check stall, clock, advance model, check ID/EX
  task automatic step(
    input logic [31:0] ins, input logic [63:0] pc, input logic v,
    input logic exs, input logic fl, input logic we,
    input logic [4:0] wr, input logic [63:0] wd, input dexp_t e
  );
    logic       hz, u1, u2;
    logic [6:0] o;
    logic [63:0] a, b;
    inst_i = ins; pc_i = pc; valid_i = v; ex_stall = exs;
    flush = fl; wb_en = we; wb_rd = wr; wb_data = wd;
    o  = ins[6:0];
    u1 = !(o == 7'h37 || o == 7'h17 || o == 7'h6F);
    u2 = o == 7'h33 || o == 7'h3B || o == 7'h23 || o == 7'h63;
    hz = v && m_valid && m_d.fl[5] && m_d.rd != 5'd0 &&
         ((m_d.rd == ins[19:15] && u1) ||
          (m_d.rd == ins[24:20] && u2));
    #1;
    chk("stall", 64'(stall), 64'(exs | hz));
    if (we && wr != 5'd0) regs[wr] = wd;
    a = regs[ins[19:15]];
    b = regs[ins[24:20]];
    @(posedge CLK);
    #1;
    if (fl) m_valid = 1'b0;
    else if (!exs) begin
      if (hz) m_valid = 1'b0;
      else begin
        m_valid = v; m_pc = pc; m_a = a; m_b = b;
        m_d = e; m_f3 = ins[14:12];
      end
    end
    compare();
  endtask

  initial begin
    kind_t       k;
    logic [31:0] ins;
    logic [63:0] im;
    logic [4:0]  rdn, r1, r2, wr;
    logic        v, exs, fl, we;
    int          ki;

    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    m_valid = 1'b0;
    reset = 1'b0; inst_i = '0; pc_i = '0; valid_i = 1'b0;
    ex_stall = 1'b0; flush = 1'b0; wb_en = 1'b0;
    wb_rd = '0; wb_data = '0;
    #12;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_pc", id_pc, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    reset = 1'b1;
    @(posedge CLK);
    #1;

    // ADDI x1,x0,5
    step(32'h00500093, 64'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd5, 1'b1, ALU_ADD, 1'b1, 5'd1, 6'o00, 1'b0));
    // LD x2,0(x1) then ADD x3,x2,x1: one bubble, then issue
    step(32'h0000B103, 64'h1004, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd2, 6'o40, 1'b0));
    step(32'h001101B3, 64'h1008, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd3, 6'o00, 1'b0));
    chk("bubble_valid", 64'(id_valid), 64'd0);
    step(32'h001101B3, 64'h1008, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd3, 6'o00, 1'b0));
    chk("add_rd", 64'(rd), 64'd3);
    // BEQ x0,x0,-8
    step(32'hFE000CE3, 64'h100C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'hFFFF_FFFF_FFFF_FFF8, 1'b1, ALU_SUB, 1'b1, 5'd0,
            6'o10, 1'b0));
    // ADD x6,x5,x0 with a same-cycle write of x5
    step(32'h00028333, 64'h1010, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,
         64'hDEAD, dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd6, 6'o00, 1'b0));
    chk("bypass", rs1_data, 64'hDEAD);
    // write to x0 is discarded
    step(32'h00000333, 64'h1014, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,
         '1, dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd6, 6'o00, 1'b0));
    step(32'h00000333, 64'h1018, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,
         64'd0, dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd6, 6'o00, 1'b0));
    chk("x0_zero", rs1_data, 64'd0);
    // ex_stall for three cycles, flush in the second
    step(32'h00500093, 64'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd5, 1'b1, ALU_ADD, 1'b1, 5'd1, 6'o00, 1'b0));
    step(32'h00028333, 64'h2004, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd6, 6'o00, 1'b0));
    chk("hold_pc", id_pc, 64'h2000);
    step(32'h00028333, 64'h2004, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0,
         dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd6, 6'o00, 1'b0));
    step(32'h00028333, 64'h2004, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd6, 6'o00, 1'b0));

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) ki = 21;
      else ki = int'($urandom_range(0, NK - 1));
      k   = kind_of(ki);
      rdn = 5'($urandom_range(0, 7));
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      enc(k, rdn, r1, r2, $urandom, ins, im);
      v   = $urandom_range(0, 7) != 0;
      exs = $urandom_range(0, 7) == 0;
      fl  = $urandom_range(0, 11) == 0;
      we  = $urandom_range(0, 1) == 1;
      wr  = 5'($urandom_range(0, 7));
      step(ins, {$urandom, $urandom}, v, exs, fl, we, wr,
           {$urandom, $urandom},
           dx(im, !k.ill, k.alu, !k.ill,
              (k.ill || k.fmt == 2 || k.fmt == 3) ? 5'd0 : rdn,
              k.ill ? 6'o00 : k.fl, k.ill));
    end

    // mid-stream reset clears ID/EX and the register file
    step(32'h00028333, 64'h3000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,
         64'h1234, dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd6, 6'o00, 1'b0));
    ex_stall = 1'b0; flush = 1'b0; wb_en = 1'b0; valid_i = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(id_valid), 64'd0);
    chk("mid_rst_pc", id_pc, 64'd0);
    chk("mid_rst_rs1", rs1_data, 64'd0);
    chk("mid_rst_rd", 64'(rd), 64'd0);
    chk("mid_rst_alu", 64'(alu_op), 64'd0);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    #2;
    reset = 1'b1;
    step(32'h00028333, 64'h3004, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd0, 1'b1, ALU_ADD, 1'b1, 5'd6, 6'o00, 1'b0));
    chk("rf_cleared", rs1_data, 64'd0);
    step(32'h0000007F, 64'h3008, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0,
         dx(64'd0, 1'b0, ALU_ADD, 1'b0, 5'd0, 6'o00, 1'b1));
    chk("illegal_7f", 64'(illegal), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
